// File: rtl/intr_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt controller.
package intr_pkg;

  localparam int unsigned NUM_IRQ = 8;
  localparam int unsigned VEC_W   = 3;

  localparam int unsigned IRQ_SWKEY = 0;
  localparam int unsigned IRQ_TIMER = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational priority search over active lines, starting at index 'start'
// and wrapping upward; the first active index found wins.
module intr_prio_enc
  import intr_pkg::*;
(
  input  logic [NUM_IRQ-1:0] active,
  input  logic [VEC_W-1:0]   start,
  output logic               any,
  output logic [VEC_W-1:0]   idx
);

  logic [VEC_W-1:0] pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      // VEC_W-bit addition wraps 7 -> 0 for free
      pos = start + VEC_W'(k);
      if (!any && active[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// 8-line interrupt controller: edge detect, pending/mask registers, priority
// select and req/ack/done handshake. Optional INTR_ROTATE_PRIO_EN: round-robin.
module intr_ctrl
  import intr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_write,
  input  logic               pend_clear,
  input  logic [NUM_IRQ-1:0] writedata,
  output logic [NUM_IRQ-1:0] mask_rdata,
  output logic [NUM_IRQ-1:0] pend_rdata,
  output logic               intr_req,
  output logic [VEC_W-1:0]   intr_vector,
  input  logic               intr_ack,
  input  logic               intr_done
);

  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vec_q, vec_d;

  logic [NUM_IRQ-1:0] rise, clr, active;
  logic               ack_take;
  logic               win_any;
  logic [VEC_W-1:0]   win_idx;
  logic [VEC_W-1:0]   prio_start;

  assign rise     = irq_in & ~irq_prev_q;
  assign ack_take = (state_q == ST_REQ) && intr_ack;
  assign clr      = ({NUM_IRQ{pend_clear}} & writedata)
                  | (ack_take ? onehot(vec_q) : '0);
  // rise is OR-ed in after the clear so a same-cycle event is never lost
  assign pend_d   = (pend_q & ~clr) | rise;
  assign mask_d   = mask_write ? writedata : mask_q;
  assign active   = pend_q & mask_q;

`ifdef INTR_ROTATE_PRIO_EN
  logic [VEC_W-1:0] ptr_q, ptr_d;

  assign ptr_d      = ack_take ? vec_q + VEC_W'(1) : ptr_q;
  assign prio_start = ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign prio_start = '0;
`endif

  intr_prio_enc u_prio_enc (
    .active (active),
    .start  (prio_start),
    .any    (win_any),
    .idx    (win_idx)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          vec_d   = win_idx;
        end
      end
      ST_REQ: begin
        // request is committed: mask changes here do not withdraw it
        if (intr_ack) begin
          state_d = ST_SERVICE;
          req_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (intr_done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q     <= '0;
      pend_q     <= '0;
      irq_prev_q <= '0;
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      vec_q      <= '0;
    end else begin
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_in;
      state_q    <= state_d;
      req_q      <= req_d;
      vec_q      <= vec_d;
    end
  end

  assign mask_rdata  = mask_q;
  assign pend_rdata  = pend_q;
  assign intr_req    = req_q;
  assign intr_vector = vec_q;

endmodule
